// File: rtl/fifo_flow_status_if.sv
// FIFO-status interface between the FIFO (producer of status) and the flow-control FSM.
//   push, data_in, pop : write/read requests from the FSM side
//   data_Fifo, valid_out : registered read data and its 1-cycle update strobe
//   count, empty_Fifo, no_empty_Fifo, full, almost_full, almost_empty : occupancy status
//   Fifo_overflow (sticky), underflow (1-cycle pulse) : error indications
// master = FIFO side, slave = FSM side.
interface fifo_flow_status_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_Fifo;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty_Fifo;
  logic                  no_empty_Fifo;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  Fifo_overflow;
  logic                  underflow;

  modport master (
    input  push, data_in, pop,
    output data_Fifo, valid_out, count, empty_Fifo, no_empty_Fifo, full,
           almost_full, almost_empty, Fifo_overflow, underflow
  );

  modport slave (
    output push, data_in, pop,
    input  data_Fifo, valid_out, count, empty_Fifo, no_empty_Fifo, full,
           almost_full, almost_empty, Fifo_overflow, underflow
  );
endinterface

// File: rtl/fifo_flow_status.sv
// Synchronous 8-entry FIFO with occupancy/error status for the flow-control FSM.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : asynchronous active-low reset; discards stored data immediately
//   bus   : fifo_flow_status_if.master
//           push/data_in/pop in; data_Fifo/valid_out (1-cycle read latency),
//           count and decoded flags, sticky Fifo_overflow, pulsed underflow out.
module fifo_flow_status #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned ALMOST_FULL  = 6,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_flow_status_if.master   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]         count_q, count_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  und_q;

  logic empty_c;
  logic full_c;
  logic wr_en;
  logic rd_en;

  // Status flags decode the registered count, so they only move on clock edges.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));

  assign bus.count         = count_q;
  assign bus.empty_Fifo    = empty_c;
  assign bus.no_empty_Fifo = ~empty_c;
  assign bus.full          = full_c;
  assign bus.almost_full   = (count_q >= CW'(ALMOST_FULL));
  assign bus.almost_empty  = (count_q <= CW'(ALMOST_EMPTY));
  assign bus.data_Fifo     = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.Fifo_overflow = ovf_q;
  assign bus.underflow     = und_q;

  // Enables use pre-edge full/empty: a read never makes room for a same-cycle
  // push, and a push never feeds a same-cycle pop (no fall-through).
  always_comb begin
    wr_en      = bus.push & ~full_c;
    rd_en      = bus.pop & ~empty_c;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    if (wr_en) wr_ptr_nxt = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_en) rd_ptr_nxt = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.data_in;
  end

  // Pointers, occupancy, read data and error indications.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      valid_q  <= rd_en;
      if (rd_en) data_q <= mem[rd_ptr_q];
      if (bus.push & full_c) ovf_q <= 1'b1;
      und_q    <= bus.pop & empty_c;
    end
  end

endmodule

// File: tb/tb_fifo_flow_status.sv
// Self-checking bench for fifo_flow_status: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_fifo_flow_status;

  logic clk;
  logic reset;

  fifo_flow_status_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fifo_flow_status #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL(6), .ALMOST_EMPTY(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: contents as a queue plus the observable registers.
  logic [7:0] q [$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;
  logic       m_und;

  function automatic void model_reset();
    q.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_und   = 1'b0;
  endfunction

  // One clock edge of FIFO behaviour, decided from the occupancy before the edge.
  function automatic void model_edge(input logic p, input logic r, input logic [7:0] d);
    int n;
    n = q.size();
    m_valid = 1'b0;
    m_und   = 1'b0;
    if (r && n > 0) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (r && n == 0) m_und = 1'b1;
    if (p && n < 8) q.push_back(d);
    if (p && n == 8) m_ovf = 1'b1;
  endfunction

  // {data, valid, count, empty, no_empty, full, almost_full, almost_empty, overflow, underflow}
  function automatic logic [19:0] model_status();
    int n;
    n = q.size();
    return {m_data, m_valid, 4'(n), (n == 0), (n != 0), (n == 8), (n >= 6), (n <= 2), m_ovf, m_und};
  endfunction

  function automatic logic [19:0] dut_status();
    return {bus.data_Fifo, bus.valid_out, bus.count, bus.empty_Fifo, bus.no_empty_Fifo,
            bus.full, bus.almost_full, bus.almost_empty, bus.Fifo_overflow, bus.underflow};
  endfunction

  // Drive one cycle (inputs change 1 time unit after an edge), sample 1 unit after the next edge.
  task automatic step(input logic p, input logic r, input logic [7:0] d);
    bus.push    = p;
    bus.pop     = r;
    bus.data_in = d;
    @(posedge clk);
    model_edge(p, r, d);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.push    = 1'b1;
    bus.pop     = 1'b0;
    bus.data_in = 8'h99;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_status() !== model_status()) begin
      failures++;
      $display("FAIL reset_status: dut=%h exp=%h", dut_status(), model_status());
    end
    checks++;
    if ({bus.count, bus.empty_Fifo, bus.no_empty_Fifo, bus.almost_empty, bus.Fifo_overflow, bus.data_Fifo}
        !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_values: count=%0d empty=%b no_empty=%b ae=%b ovf=%b data=%h",
               bus.count, bus.empty_Fifo, bus.no_empty_Fifo, bus.almost_empty, bus.Fifo_overflow, bus.data_Fifo);
    end
    bus.push = 1'b0;
    reset    = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 + i));
      checks++;
      if (dut_status() !== model_status()) begin
        failures++;
        $display("FAIL fill[%0d]: dut=%h exp=%h", i, dut_status(), model_status());
      end
      checks++;
      if ({bus.almost_empty, bus.almost_full} !== {(i < 2), (i >= 5)}) begin
        failures++;
        $display("FAIL fill_flags[%0d]: ae=%b af=%b exp ae=%b af=%b", i,
                 bus.almost_empty, bus.almost_full, (i < 2), (i >= 5));
      end
    end
    checks++;
    if ({bus.full, bus.count} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL fill_full: full=%b count=%0d exp full=1 count=8", bus.full, bus.count);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 8'hAA);
    checks++;
    if ({bus.count, bus.Fifo_overflow} !== {4'd8, 1'b1}) begin
      failures++;
      $display("FAIL overflow_set: count=%0d ovf=%b exp count=8 ovf=1", bus.count, bus.Fifo_overflow);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      checks++;
      if ({bus.data_Fifo, bus.valid_out} !== {8'(8'h11 + i), 1'b1}) begin
        failures++;
        $display("FAIL overflow_drain[%0d]: data=%h valid=%b exp data=%h valid=1",
                 i, bus.data_Fifo, bus.valid_out, 8'(8'h11 + i));
      end
      checks++;
      if (dut_status() !== model_status()) begin
        failures++;
        $display("FAIL overflow_status[%0d]: dut=%h exp=%h", i, dut_status(), model_status());
      end
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus.Fifo_overflow, bus.valid_out, bus.empty_Fifo} !== 3'b101) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%b valid=%b empty=%b exp 1 0 1",
               bus.Fifo_overflow, bus.valid_out, bus.empty_Fifo);
    end
  endtask

  task automatic test_wrap_simultaneous();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    checks++;
    if (dut_status() !== model_status()) begin
      failures++;
      $display("FAIL wrap_prep: dut=%h exp=%h", dut_status(), model_status());
    end
    for (int k = 0; k < 7; k++) begin
      step(k < 6, k >= 1, 8'(8'h21 + k));
      checks++;
      if (dut_status() !== model_status()) begin
        failures++;
        $display("FAIL wrap[%0d]: dut=%h exp=%h", k, dut_status(), model_status());
      end
      if (k >= 1) begin
        checks++;
        if ({bus.data_Fifo, bus.valid_out} !== {8'(8'h21 + k - 1), 1'b1}) begin
          failures++;
          $display("FAIL wrap_data[%0d]: data=%h valid=%b exp data=%h valid=1",
                   k, bus.data_Fifo, bus.valid_out, 8'(8'h21 + k - 1));
        end
      end
    end
    checks++;
    if (bus.count !== 4'd0) begin
      failures++;
      $display("FAIL wrap_end_count: count=%0d exp 0", bus.count);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] held;
    held = bus.data_Fifo;
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({bus.underflow, bus.valid_out, bus.data_Fifo} !== {1'b1, 1'b0, held}) begin
      failures++;
      $display("FAIL underflow_pop: und=%b valid=%b data=%h exp und=1 valid=0 data=%h",
               bus.underflow, bus.valid_out, bus.data_Fifo, held);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pulse: und=%b exp 0", bus.underflow);
    end
    step(1'b1, 1'b1, 8'h77);
    checks++;
    if ({bus.count, bus.underflow, bus.valid_out} !== {4'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL underflow_pushpop: count=%0d und=%b valid=%b exp count=1 und=1 valid=0",
               bus.count, bus.underflow, bus.valid_out);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (dut_status() !== model_status()) begin
      failures++;
      $display("FAIL underflow_drain: dut=%h exp=%h", dut_status(), model_status());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({bus.count, bus.Fifo_overflow} !== {4'd5, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_prep: count=%0d ovf=%b exp count=5 ovf=1", bus.count, bus.Fifo_overflow);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.count, bus.Fifo_overflow, bus.empty_Fifo} !== {4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_async: count=%0d ovf=%b empty=%b exp count=0 ovf=0 empty=1",
               bus.count, bus.Fifo_overflow, bus.empty_Fifo);
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if ({bus.data_Fifo, bus.valid_out, bus.count} !== {8'h5A, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL reset_mid_after: data=%h valid=%b count=%0d exp data=5a valid=1 count=0",
               bus.data_Fifo, bus.valid_out, bus.count);
    end
  endtask

  task automatic test_random();
    int push_pct;
    for (int i = 0; i < 600; i++) begin
      push_pct = ((i / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < push_pct, $urandom_range(99) >= push_pct, 8'($urandom));
      checks++;
      if (dut_status() !== model_status()) begin
        failures++;
        $display("FAIL random[%0d]: dut=%h exp=%h", i, dut_status(), model_status());
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 8'h00;
    test_reset();
    test_fill();
    test_overflow();
    test_wrap_simultaneous();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
